// File: rtl/weight_fetch_sched_if.sv
// Stream/store bundle between weight_fetch_sched, the weight ROM and the conv engines.
// Latency: none (wires only).
// Backpressure: w_ready from the sink, qualified by grant.
// master: scheduler side (drives grant, rom_read, w_* stream, done).
// slave: environment side (drives req, rom_data, w_ready).
interface weight_fetch_sched_if #(
    parameter int BIT_WIDTH = 8,
    parameter int SIZE      = 26,
    parameter int NUM_REQ   = 4
);
    localparam int DST_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        grant;
    logic                      rom_read;
    logic [BIT_WIDTH*SIZE-1:0] rom_data;
    logic                      w_valid;
    logic                      w_ready;
    logic [BIT_WIDTH-1:0]      w_data;
    logic                      w_last;
    logic [DST_W-1:0]          w_dst;
    logic [NUM_REQ-1:0]        done;

    modport master (
        input  req, rom_data, w_ready,
        output grant, rom_read, w_valid, w_data, w_last, w_dst, done
    );

    modport slave (
        output req, rom_data, w_ready,
        input  grant, rom_read, w_valid, w_data, w_last, w_dst, done
    );
endinterface

// File: rtl/weight_fetch_sched.sv
// Round-robin share of one kernel store among NUM_REQ engines; serializes SIZE words per grant.
// Latency: grant+rom_read 1 cycle after req, word i at cycle 2+i, done at SIZE+2; SIZE+2 cycles/txn.
// Backpressure: w_valid/w_ready; word, last, dst and grant hold while stalled.
// Ports: clk, rst (sync, active-high); bus = weight_fetch_sched_if.master carrying
//        req/grant/done per engine, rom_read/rom_data to the store, w_valid/w_ready/w_data/w_last/w_dst stream.
module weight_fetch_sched #(
    parameter int BIT_WIDTH = 8,
    parameter int SIZE      = 26,
    parameter int NUM_REQ   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    weight_fetch_sched_if.master  bus
);
    localparam int DST_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [DST_W-1:0]   dst_q, dst_d;
    logic [DST_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic               found;
    logic [DST_W-1:0]   pick;
    int                 cand;
    logic               last;
    logic [BIT_WIDTH-1:0] word;

    // Round-robin pick: first set req bit at or above ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && bus.req[DST_W'(cand)]) begin
                found = 1'b1;
                pick  = DST_W'(cand);
            end
        end
    end

    // Word select from the store output, which stays stable until the next fetch.
    always_comb begin
        word = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                word = bus.rom_data[i*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    assign last = (state_q == STREAM) && (idx_q == IDX_W'(SIZE - 1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        dst_d   = dst_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        done_d  = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                    dst_d   = pick;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                idx_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (bus.w_ready) begin
                    if (last) begin
                        state_d = IDLE;
                        grant_d = '0;
                        dst_d   = '0;
                        done_d  = grant_q;
                        ptr_d   = (dst_q == DST_W'(NUM_REQ - 1)) ? '0 : dst_q + 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            dst_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            dst_q   <= dst_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.grant    = grant_q;
    assign bus.rom_read = (state_q == FETCH);
    assign bus.w_valid  = (state_q == STREAM);
    assign bus.w_data   = (state_q == STREAM) ? word : '0;
    assign bus.w_last   = last;
    assign bus.w_dst    = dst_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_weight_fetch_sched.sv
module tb_weight_fetch_sched;
    localparam int BW = 8;
    localparam int SZ = 26;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    weight_fetch_sched_if #(.BIT_WIDTH(BW), .SIZE(SZ), .NUM_REQ(NR)) bus ();
    weight_fetch_sched #(.BIT_WIDTH(BW), .SIZE(SZ), .NUM_REQ(NR)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    weight_fetch_sched_if #(.BIT_WIDTH(8), .SIZE(1), .NUM_REQ(2)) bus2 ();
    weight_fetch_sched #(.BIT_WIDTH(8), .SIZE(1), .NUM_REQ(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    int checks = 0;
    int errors = 0;
    int exp_gen = 0;

    // Kernel store model: captures a new kernel set at the end of each read cycle.
    logic [BW*SZ-1:0] rom_q = '0;
    int               rom_gen = 0;
    logic [7:0]       rom2_q = '0;
    int               rom2_gen = 0;
    assign bus.rom_data  = rom_q;
    assign bus2.rom_data = rom2_q;

    function automatic logic [7:0] word_of(input int g, input int i);
        return 8'((g % 8) * 32 + i);
    endfunction

    always @(posedge clk) begin
        if (bus.rom_read) begin
            rom_gen <= rom_gen + 1;
            for (int i = 0; i < SZ; i++) rom_q[i*BW +: BW] <= word_of(rom_gen + 1, i);
        end
        if (bus2.rom_read) begin
            rom2_gen <= rom2_gen + 1;
            rom2_q   <= 8'hC3 + 8'(rom2_gen);
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [20:0] outs();
        return {bus.grant, bus.rom_read, bus.w_valid, bus.w_data, bus.w_last, bus.w_dst, bus.done};
    endfunction

    function automatic logic [7:0] outs2();
        return {bus2.grant, bus2.rom_read, bus2.w_valid, bus2.w_last, bus2.w_dst, bus2.done};
    endfunction

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic [3:0] grant;
        logic       rd;
        logic       vld;
        logic [7:0] dat;
        logic       last;
        logic [1:0] dst;
        logic [3:0] done;
    } vec_t;

    vec_t vec[30];

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;  bus.w_ready = 1'b0;
        bus2.req = '0; bus2.w_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out", 256'(outs()), 256'(0));
        chk("reset_out2", 256'({outs2(), bus2.w_data}), 256'(0));
    endtask

    // One transaction: drives req, ready pattern (bp) and optional req drop, then checks the result.
    task automatic run_txn(input string nm, input logic [3:0] req_v, input logic [3:0] exp_g,
                           input bit bp, input int drop_word);
        logic [7:0]  words[$];
        logic [3:0]  g_first = '0;
        logic [3:0]  done_v = '0;
        logic [15:0] snap = '0;
        bit          stalled = 0;
        int          rd_cnt = 0;
        int          stable_bad = 0;
        int          sc = 0;
        int          bad_at = -1;
        logic [3:0]  pat = 4'b1001;
        bus.req = req_v;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1 bus.w_ready = bp ? pat[c % 4] : 1'b1;
            @(negedge clk);
            if (bus.rom_read) rd_cnt++;
            if (bus.grant != 0 && g_first == 0) g_first = bus.grant;
            if (stalled) begin
                if ({bus.w_valid, bus.w_data, bus.w_last, bus.w_dst, bus.grant} !== snap) stable_bad++;
                stalled = 0;
            end
            if (bus.w_valid) begin
                if (drop_word >= 0 && sc == drop_word) bus.req = req_v & ~exp_g;
                sc++;
                if (bus.w_ready) words.push_back(bus.w_data);
                else begin
                    stalled = 1;
                    snap = {bus.w_valid, bus.w_data, bus.w_last, bus.w_dst, bus.grant};
                end
            end
            if (bus.done != 0) begin
                done_v = bus.done;
                break;
            end
        end
        bus.req = '0;
        exp_gen++;
        chk({nm, "_grant"}, 256'(g_first), 256'(exp_g));
        chk({nm, "_nwords"}, 256'(words.size()), 256'(SZ));
        foreach (words[i]) if (bad_at < 0 && words[i] !== word_of(exp_gen, i)) bad_at = i;
        chk({nm, "_first_bad_word"}, 256'(bad_at), 256'(-1));
        chk({nm, "_rom_read_cnt"}, 256'(rd_cnt), 256'(1));
        chk({nm, "_done"}, 256'(done_v), 256'(exp_g));
        chk({nm, "_stall_stable"}, 256'(stable_bad), 256'(0));
    endtask

    initial begin
        logic [3:0] gq[$];
        int         dcyc[$];
        int         onehot_bad;
        logic [3:0] prev_g;
        bit         found;

        // Single request, engine 2, ready held high.
        for (int k = 0; k < 30; k++) begin
            vec[k] = '{default: '0};
            vec[k].req = (k <= 27) ? 4'b0100 : 4'b0000;
            vec[k].rdy = 1'b1;
            if (k >= 1 && k <= 27) begin
                vec[k].grant = 4'b0100;
                vec[k].dst   = 2'd2;
            end
            if (k == 1) vec[k].rd = 1'b1;
            if (k >= 2 && k <= 27) begin
                vec[k].vld  = 1'b1;
                vec[k].dat  = word_of(1, k - 2);
                vec[k].last = (k == 27);
            end
            if (k == 28) vec[k].done = 4'b0100;
        end

        do_reset();
        exp_gen = 1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1 bus.req = vec[k].req;
            bus.w_ready = vec[k].rdy;
            @(negedge clk);
            chk($sformatf("single_c%0d", k), 256'(outs()),
                256'({vec[k].grant, vec[k].rd, vec[k].vld, vec[k].dat, vec[k].last, vec[k].dst, vec[k].done}));
        end

        // Round-robin fairness with all requests held.
        do_reset();
        bus.w_ready = 1'b1;
        bus.req = 4'b1111;
        onehot_bad = 0;
        prev_g = '0;
        for (int c = 0; c < 200 && dcyc.size() < 5; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (!$onehot0(bus.grant)) onehot_bad++;
            if (bus.grant != 0 && prev_g == 0) gq.push_back(bus.grant);
            prev_g = bus.grant;
            if (bus.done != 0) dcyc.push_back(c);
        end
        bus.req = '0;
        exp_gen += 5;
        chk("rr_onehot", 256'(onehot_bad), 256'(0));
        chk("rr_ndone", 256'(dcyc.size()), 256'(5));
        for (int i = 0; i < 5; i++)
            chk($sformatf("rr_grant%0d", i), 256'((i < gq.size()) ? gq[i] : 4'h0), 256'(4'b0001 << (i % 4)));
        if (dcyc.size() > 0) chk("rr_first_done_cycle", 256'(dcyc[0]), 256'(27));
        for (int i = 1; i < dcyc.size(); i++)
            chk($sformatf("rr_done_gap%0d", i), 256'(dcyc[i] - dcyc[i-1]), 256'(28));

        // Backpressure 1,0,0,1.
        do_reset();
        run_txn("bp", 4'b0001, 4'b0001, 1'b1, -1);

        // Request withdrawn in the 5th stream cycle.
        do_reset();
        run_txn("withdraw", 4'b0010, 4'b0010, 1'b0, 4);

        // Reset mid-transaction: serve engine 2 (ptr -> 3), start engine 3, reset at word 10.
        do_reset();
        run_txn("pre", 4'b0100, 4'b0100, 1'b0, -1);
        bus.req = 4'b1000;
        bus.w_ready = 1'b1;
        found = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (bus.w_valid && bus.w_data == word_of(exp_gen + 1, 10)) begin
                found = 1;
                break;
            end
        end
        chk("mid_word10_seen", 256'(found), 256'(1));
        exp_gen++;
        rst = 1'b1;
        bus.req = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_reset_out", 256'(outs()), 256'(0));
        run_txn("after_rst", 4'b1010, 4'b0010, 1'b0, -1);

        // NUM_REQ=2, SIZE=1 instance.
        do_reset();
        bus2.w_ready = 1'b1;
        bus2.req = 2'b10;
        @(posedge clk); #1; @(negedge clk);
        chk("n2_c1", 256'(outs2()), 256'({2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00}));
        @(posedge clk); #1; @(negedge clk);
        chk("n2_c2", 256'(outs2()), 256'({2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00}));
        chk("n2_data", 256'(bus2.w_data), 256'(8'hC3));
        @(posedge clk);
        #1 bus2.req = '0;
        @(negedge clk);
        chk("n2_c3", 256'(outs2()), 256'({2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10}));
        @(posedge clk); #1; @(negedge clk);
        chk("n2_c4", 256'(outs2()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
